// File: rtl/turing_machine.sv
// turing_machine
//   User-programmable two-symbol Turing machine with a circular 1-bit tape.
//   The machine is driven by a 6-bit data input and two level buttons.
//   It moves through three entry/run phases:
//     PROGRAM : Next rises load N, then (write, direction, next) for every
//               (state 1..N, symbol 0/1) pair.
//     TAPE    : the first Next loads the head start address; later Nexts write
//               cells and advance the head.
//     RUN     : a Next rise reads, writes and latches; the Next fall moves the
//               head and changes state.
//   A Done rise ends PROGRAM and TAPE. Halting (direction 2 or 3) is sticky
//   until reset.
// Ports
//   clock, reset     : system clock, synchronous active-high reset
//   input_data[5:0]  : user entry value
//   Next, Done       : level buttons, acted upon at their edges
//   display_out[10:0]: tape window, bit k = tape[(head-k) mod TAPE_LEN]
//   Compute_done     : machine halted (sticky)
//   currState        : current machine state
//   tape_reg_out     : symbol under the head
//   data_reg_out     : symbol latched for writing on the current step
//   direction_out    : direction latched for the current step
//   next_state_out   : next state latched for the current step, zero-extended
//   tape_addr_out    : head address
// All outputs are registered.
module turing_machine #(
  parameter int STATE_W  = 4,
  parameter int TAPE_LEN = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [5:0]                  input_data,
  input  logic                        Next,
  input  logic                        Done,
  output logic [10:0]                 display_out,
  output logic                        Compute_done,
  output logic [STATE_W-1:0]          currState,
  output logic                        tape_reg_out,
  output logic                        data_reg_out,
  output logic [1:0]                  direction_out,
  output logic [5:0]                  next_state_out,
  output logic [$clog2(TAPE_LEN)-1:0] tape_addr_out
);

  localparam int AW     = $clog2(TAPE_LEN);
  localparam int NENT   = 2 * (2 ** STATE_W);
  localparam int DISP_W = 11;
  localparam logic [STATE_W-1:0] STATE_ONE = {{(STATE_W-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]      ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    PH_PROGRAM = 2'd0,
    PH_TAPE    = 2'd1,
    PH_RUN     = 2'd2,
    PH_HALT    = 2'd3
  } phase_t;

  phase_t               phase_r, phase_nxt_s;
  logic                 next_prev_r, done_prev_r;
  logic                 next_rise_s, next_fall_s, done_rise_s, next_act_s;

  logic [TAPE_LEN-1:0]  tape_r, tape_nxt_s;
  logic [AW-1:0]        head_r, head_nxt_s;
  logic [AW-1:0]        start_r, start_nxt_s;
  logic                 have_start_r, have_start_nxt_s;

  // Program-entry pointer: (state, symbol, field) of the next entry to fill.
  logic                 have_n_r, have_n_nxt_s;
  logic [STATE_W-1:0]   prog_n_r, prog_n_nxt_s;
  logic [STATE_W-1:0]   prog_state_r, prog_state_nxt_s;
  logic                 prog_sym_r, prog_sym_nxt_s;
  logic [1:0]           prog_field_r, prog_field_nxt_s;
  logic                 prog_full_r, prog_full_nxt_s;

  // Transition table indexed by {state, symbol}.
  logic                 tbl_wr_r  [NENT];
  logic                 tbl_wr_nxt_s [NENT];
  logic [1:0]           tbl_dir_r [NENT];
  logic [1:0]           tbl_dir_nxt_s [NENT];
  logic [STATE_W-1:0]   tbl_nx_r  [NENT];
  logic [STATE_W-1:0]   tbl_nx_nxt_s [NENT];

  logic                 lat_wr_r, lat_wr_nxt_s;
  logic [1:0]           lat_dir_r, lat_dir_nxt_s;
  logic [5:0]           lat_nx_r, lat_nx_nxt_s;
  // Set by a processed Next rise in RUN so that only its matching fall moves.
  logic                 pending_r, pending_nxt_s;
  logic [STATE_W-1:0]   curr_r, curr_nxt_s;
  logic                 done_flag_r, done_flag_nxt_s;
  logic [DISP_W-1:0]    disp_r, disp_nxt_s;
  logic                 cell_r, cell_nxt_s;

  logic [STATE_W:0]     prog_idx_s, run_idx_s;

  assign next_rise_s = Next & ~next_prev_r;
  assign next_fall_s = ~Next & next_prev_r;
  assign done_rise_s = Done & ~done_prev_r;
  // A simultaneous Done rise swallows the Next press.
  assign next_act_s  = next_rise_s & ~done_rise_s;

  assign prog_idx_s  = {prog_state_r, prog_sym_r};
  assign run_idx_s   = {curr_r, tape_r[head_r]};

  // Phase register.
  always_ff @(posedge clock) begin
    if (reset) phase_r <= PH_PROGRAM;
    else       phase_r <= phase_nxt_s;
  end

  // Phase transitions.
  always_comb begin
    phase_nxt_s = phase_r;
    case (phase_r)
      PH_PROGRAM: begin
        if (done_rise_s) phase_nxt_s = PH_TAPE;
        else             phase_nxt_s = PH_PROGRAM;
      end
      PH_TAPE: begin
        if (done_rise_s) phase_nxt_s = PH_RUN;
        else             phase_nxt_s = PH_TAPE;
      end
      PH_RUN: begin
        // Directions 2 and 3 both halt: bit 1 set.
        if (next_fall_s && pending_r && lat_dir_r[1]) phase_nxt_s = PH_HALT;
        else                                          phase_nxt_s = PH_RUN;
      end
      PH_HALT:  phase_nxt_s = PH_HALT;
      default:  phase_nxt_s = PH_PROGRAM;
    endcase
  end

  // Datapath next values for each phase.
  always_comb begin
    tape_nxt_s       = tape_r;
    head_nxt_s       = head_r;
    start_nxt_s      = start_r;
    have_start_nxt_s = have_start_r;
    have_n_nxt_s     = have_n_r;
    prog_n_nxt_s     = prog_n_r;
    prog_state_nxt_s = prog_state_r;
    prog_sym_nxt_s   = prog_sym_r;
    prog_field_nxt_s = prog_field_r;
    prog_full_nxt_s  = prog_full_r;
    tbl_wr_nxt_s     = tbl_wr_r;
    tbl_dir_nxt_s    = tbl_dir_r;
    tbl_nx_nxt_s     = tbl_nx_r;
    lat_wr_nxt_s     = lat_wr_r;
    lat_dir_nxt_s    = lat_dir_r;
    lat_nx_nxt_s     = lat_nx_r;
    pending_nxt_s    = pending_r;
    curr_nxt_s       = curr_r;
    done_flag_nxt_s  = done_flag_r;
    case (phase_r)
      PH_PROGRAM: begin
        if (next_act_s && !have_n_r) begin
          have_n_nxt_s     = 1'b1;
          prog_n_nxt_s     = input_data[STATE_W-1:0];
          prog_state_nxt_s = STATE_ONE;
          prog_sym_nxt_s   = 1'b0;
          prog_field_nxt_s = 2'd0;
          prog_full_nxt_s  = (input_data[STATE_W-1:0] == {STATE_W{1'b0}});
        end else if (next_act_s && !prog_full_r) begin
          case (prog_field_r)
            2'd0:    tbl_wr_nxt_s[prog_idx_s]  = input_data[0];
            2'd1:    tbl_dir_nxt_s[prog_idx_s] = input_data[1:0];
            2'd2:    tbl_nx_nxt_s[prog_idx_s]  = input_data[STATE_W-1:0];
            default: tbl_wr_nxt_s[prog_idx_s]  = tbl_wr_r[prog_idx_s];
          endcase
          if (prog_field_r == 2'd2) begin
            prog_field_nxt_s = 2'd0;
            if (prog_sym_r) begin
              prog_sym_nxt_s   = 1'b0;
              prog_state_nxt_s = prog_state_r + STATE_ONE;
              prog_full_nxt_s  = (prog_state_r == prog_n_r);
            end else begin
              prog_sym_nxt_s   = 1'b1;
            end
          end else begin
            prog_field_nxt_s = prog_field_r + 2'd1;
          end
        end else begin
          prog_full_nxt_s = prog_full_r;
        end
      end
      PH_TAPE: begin
        if (done_rise_s) begin
          head_nxt_s = start_r;
          curr_nxt_s = STATE_ONE;
        end else if (next_act_s && !have_start_r) begin
          have_start_nxt_s = 1'b1;
          start_nxt_s      = input_data[AW-1:0];
          head_nxt_s       = input_data[AW-1:0];
        end else if (next_act_s) begin
          tape_nxt_s[head_r] = input_data[0];
          head_nxt_s         = head_r + ADDR_ONE;
        end else begin
          head_nxt_s = head_r;
        end
      end
      PH_RUN: begin
        if (next_act_s) begin
          tape_nxt_s[head_r]            = tbl_wr_r[run_idx_s];
          lat_wr_nxt_s                  = tbl_wr_r[run_idx_s];
          lat_dir_nxt_s                 = tbl_dir_r[run_idx_s];
          lat_nx_nxt_s                  = {6{1'b0}};
          lat_nx_nxt_s[STATE_W-1:0]     = tbl_nx_r[run_idx_s];
          pending_nxt_s                 = 1'b1;
        end else if (next_fall_s && pending_r) begin
          pending_nxt_s = 1'b0;
          curr_nxt_s    = lat_nx_r[STATE_W-1:0];
          case (lat_dir_r)
            2'd0:    head_nxt_s      = head_r + ADDR_ONE;
            2'd1:    head_nxt_s      = head_r - ADDR_ONE;
            default: done_flag_nxt_s = 1'b1;
          endcase
        end else begin
          pending_nxt_s = pending_r;
        end
      end
      PH_HALT:  done_flag_nxt_s = 1'b1;
      default:  done_flag_nxt_s = done_flag_r;
    endcase
  end

  // Display window and head cell from the post-edge tape and head, so that a
  // RUN write shows up on the same edge it happens.
  always_comb begin
    disp_nxt_s = {DISP_W{1'b0}};
    for (int k = 0; k < DISP_W; k++) begin
      disp_nxt_s[k] = tape_nxt_s[head_nxt_s - k[AW-1:0]];
    end
    cell_nxt_s = tape_nxt_s[head_nxt_s];
  end

  // Datapath, button history and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      next_prev_r  <= 1'b0;
      done_prev_r  <= 1'b0;
      tape_r       <= {TAPE_LEN{1'b0}};
      head_r       <= {AW{1'b0}};
      start_r      <= {AW{1'b0}};
      have_start_r <= 1'b0;
      have_n_r     <= 1'b0;
      prog_n_r     <= {STATE_W{1'b0}};
      prog_state_r <= {STATE_W{1'b0}};
      prog_sym_r   <= 1'b0;
      prog_field_r <= 2'd0;
      prog_full_r  <= 1'b0;
      for (int i = 0; i < NENT; i++) begin
        tbl_wr_r[i]  <= 1'b0;
        tbl_dir_r[i] <= 2'd0;
        tbl_nx_r[i]  <= {STATE_W{1'b0}};
      end
      lat_wr_r     <= 1'b0;
      lat_dir_r    <= 2'd0;
      lat_nx_r     <= 6'd0;
      pending_r    <= 1'b0;
      curr_r       <= {STATE_W{1'b0}};
      done_flag_r  <= 1'b0;
      disp_r       <= {DISP_W{1'b0}};
      cell_r       <= 1'b0;
    end else begin
      next_prev_r  <= Next;
      done_prev_r  <= Done;
      tape_r       <= tape_nxt_s;
      head_r       <= head_nxt_s;
      start_r      <= start_nxt_s;
      have_start_r <= have_start_nxt_s;
      have_n_r     <= have_n_nxt_s;
      prog_n_r     <= prog_n_nxt_s;
      prog_state_r <= prog_state_nxt_s;
      prog_sym_r   <= prog_sym_nxt_s;
      prog_field_r <= prog_field_nxt_s;
      prog_full_r  <= prog_full_nxt_s;
      tbl_wr_r     <= tbl_wr_nxt_s;
      tbl_dir_r    <= tbl_dir_nxt_s;
      tbl_nx_r     <= tbl_nx_nxt_s;
      lat_wr_r     <= lat_wr_nxt_s;
      lat_dir_r    <= lat_dir_nxt_s;
      lat_nx_r     <= lat_nx_nxt_s;
      pending_r    <= pending_nxt_s;
      curr_r       <= curr_nxt_s;
      done_flag_r  <= done_flag_nxt_s;
      disp_r       <= disp_nxt_s;
      cell_r       <= cell_nxt_s;
    end
  end

  assign display_out    = disp_r;
  assign Compute_done   = done_flag_r;
  assign currState      = curr_r;
  assign tape_reg_out   = cell_r;
  assign data_reg_out   = lat_wr_r;
  assign direction_out  = lat_dir_r;
  assign next_state_out = lat_nx_r;
  assign tape_addr_out  = head_r;

endmodule

// File: tb/tb_turing_machine.sv
// Self-checking bench for turing_machine: directed unary-adder table, hand
// sequences for button/boundary corners, then randomized programs checked
// against a behavioural machine model.
module tb_turing_machine;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  input_data;
  logic        Next;
  logic        Done;
  logic [10:0] display_out;
  logic        Compute_done;
  logic [3:0]  currState;
  logic        tape_reg_out;
  logic        data_reg_out;
  logic [1:0]  direction_out;
  logic [5:0]  next_state_out;
  logic [5:0]  tape_addr_out;

  turing_machine #(.STATE_W(4), .TAPE_LEN(64)) dut (
    .clock(clock), .reset(reset), .input_data(input_data), .Next(Next), .Done(Done),
    .display_out(display_out), .Compute_done(Compute_done), .currState(currState),
    .tape_reg_out(tape_reg_out), .data_reg_out(data_reg_out),
    .direction_out(direction_out), .next_state_out(next_state_out),
    .tape_addr_out(tape_addr_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference machine
  bit       m_tape [64];
  int       m_head, m_state, m_start;
  bit       m_done, m_pend;
  bit       m_wr   [16][2];
  int       m_dir  [16][2];
  int       m_nx   [16][2];
  bit       m_lwr;
  int       m_ldir, m_lnx;

  typedef struct {
    logic [10:0] disp_press;
    logic [10:0] disp_rel;
    logic [3:0]  state_rel;
    logic [5:0]  head_rel;
  } step_vec_t;

  step_vec_t vecs [10];
  int adder_prog [18];
  int adder_tape [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [5:0] d);
    input_data = d;
    Next = 1'b1;
    tick();
    Next = 1'b0;
    tick();
  endtask

  task automatic done_press();
    Done = 1'b1;
    tick();
    Done = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    Next  = 1'b0;
    Done  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 64; i++) m_tape[i] = 1'b0;
    for (int s = 0; s < 16; s++) begin
      for (int r = 0; r < 2; r++) begin
        m_wr[s][r] = 1'b0; m_dir[s][r] = 0; m_nx[s][r] = 0;
      end
    end
    m_head = 0; m_state = 0; m_start = 0; m_done = 1'b0; m_pend = 1'b0;
    m_lwr = 1'b0; m_ldir = 0; m_lnx = 0;
  endtask

  function automatic logic [10:0] m_disp();
    logic [10:0] d;
    for (int k = 0; k < 11; k++) d[k] = m_tape[(m_head - k + 64) % 64];
    return d;
  endfunction

  // One press/release step, both halves compared against the model.
  task automatic run_step(input int hold);
    int sym;
    if (!m_done) begin
      sym    = m_tape[m_head];
      m_lwr  = m_wr[m_state][sym];
      m_ldir = m_dir[m_state][sym];
      m_lnx  = m_nx[m_state][sym];
      m_tape[m_head] = m_lwr;
      m_pend = 1'b1;
    end
    input_data = 6'($urandom);
    Next = 1'b1;
    repeat (hold) tick();
    chk("press_display", display_out, m_disp());
    chk("press_done", Compute_done, m_done);
    if (!m_done) begin
      chk("press_data_reg", data_reg_out, m_lwr);
      chk("press_direction", direction_out, m_ldir);
      chk("press_next_state", next_state_out, m_lnx);
      chk("press_tape_reg", tape_reg_out, m_tape[m_head]);
    end
    Next = 1'b0;
    tick();
    if (!m_done && m_pend) begin
      m_pend = 1'b0;
      if (m_ldir == 0)      m_head = (m_head + 1) % 64;
      else if (m_ldir == 1) m_head = (m_head + 63) % 64;
      else                  m_done = 1'b1;
      m_state = m_lnx;
    end
    chk("rel_display", display_out, m_disp());
    chk("rel_state", currState, m_state);
    chk("rel_head", tape_addr_out, m_head);
    chk("rel_done", Compute_done, m_done);
  endtask

  initial begin
    adder_prog = '{1,0,2, 1,0,1, 0,1,3, 1,0,2, 0,2,3, 0,2,3};
    adder_tape = '{1,1,1,1,0,1,1,1,0};
    vecs[0] = '{11'b00000000001, 11'b00000000011, 4'd1, 6'd33};
    vecs[1] = '{11'b00000000011, 11'b00000000111, 4'd1, 6'd34};
    vecs[2] = '{11'b00000000111, 11'b00000001111, 4'd1, 6'd35};
    vecs[3] = '{11'b00000001111, 11'b00000011110, 4'd1, 6'd36};
    vecs[4] = '{11'b00000011111, 11'b00000111111, 4'd2, 6'd37};
    vecs[5] = '{11'b00000111111, 11'b00001111111, 4'd2, 6'd38};
    vecs[6] = '{11'b00001111111, 11'b00011111111, 4'd2, 6'd39};
    vecs[7] = '{11'b00011111111, 11'b00111111110, 4'd2, 6'd40};
    vecs[8] = '{11'b00111111110, 11'b00011111111, 4'd3, 6'd39};
    vecs[9] = '{11'b00011111110, 11'b00011111110, 4'd3, 6'd39};

    input_data = 6'd0;
    reset = 1'b1; Next = 1'b0; Done = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_display", display_out, 11'd0);
    chk("reset_state", currState, 4'd0);
    chk("reset_done", Compute_done, 1'b0);
    chk("reset_head", tape_addr_out, 6'd0);
    chk("reset_direction", direction_out, 2'd0);
    chk("reset_next_state", next_state_out, 6'd0);

    // Unary adder
    press(6'd3);
    for (int i = 0; i < 18; i++) press(6'(adder_prog[i]));
    done_press();
    press(6'd32);
    for (int i = 0; i < 9; i++) press(6'(adder_tape[i]));
    done_press();
    chk("adder_load_display", display_out, 11'b00000000001);
    chk("adder_load_state", currState, 4'd1);
    chk("adder_load_head", tape_addr_out, 6'd32);
    for (int i = 0; i < 10; i++) begin
      Next = 1'b1;
      tick();
      chk("adder_press_display", display_out, vecs[i].disp_press);
      chk("adder_press_done", Compute_done, 1'b0);
      Next = 1'b0;
      tick();
      chk("adder_rel_display", display_out, vecs[i].disp_rel);
      chk("adder_rel_state", currState, vecs[i].state_rel);
      chk("adder_rel_head", tape_addr_out, vecs[i].head_rel);
      chk("adder_rel_done", Compute_done, (i == 9) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      press(6'd1);
      chk("halted_display", display_out, 11'b00011111110);
      chk("halted_done", Compute_done, 1'b1);
      chk("halted_head", tape_addr_out, 6'd39);
    end
    do_reset();
    chk("post_reset_display", display_out, 11'd0);
    chk("post_reset_done", Compute_done, 1'b0);
    chk("post_reset_state", currState, 4'd0);

    // Next held for six cycles consumes only the N entry
    do_reset();
    input_data = 6'd1;
    Next = 1'b1;
    repeat (6) tick();
    Next = 1'b0;
    tick();
    press(6'd1); press(6'd2); press(6'd1);
    done_press();
    press(6'd5);
    done_press();
    Next = 1'b1;
    tick();
    chk("hold_direction", direction_out, 2'd2);
    chk("hold_data_reg", data_reg_out, 1'b1);
    chk("hold_next_state", next_state_out, 6'd1);
    chk("hold_display", display_out, 11'b00000000001);
    Next = 1'b0;
    tick();
    chk("hold_halted", Compute_done, 1'b1);
    chk("hold_head", tape_addr_out, 6'd5);

    // Right move from address 63 wraps to 0
    do_reset();
    press(6'd1); press(6'd0); press(6'd0); press(6'd1);
    done_press();
    press(6'd63);
    done_press();
    chk("wrap_start", tape_addr_out, 6'd63);
    press(6'd0);
    chk("wrap_head", tape_addr_out, 6'd0);
    chk("wrap_state", currState, 4'd1);

    // Next and Done rising together: Next is discarded
    do_reset();
    press(6'd1);
    input_data = 6'd1;
    Next = 1'b1; Done = 1'b1;
    tick();
    Next = 1'b0; Done = 1'b0;
    tick();
    press(6'd7);
    done_press();
    Next = 1'b1;
    tick();
    chk("same_edge_data_reg", data_reg_out, 1'b0);
    chk("same_edge_display", display_out, 11'd0);
    Next = 1'b0;
    tick();
    chk("same_edge_head", tape_addr_out, 6'd8);

    // Randomized programs against the model
    for (int it = 0; it < 40; it++) begin
      int n, cnt, start, len, rst_at, extra;
      logic [5:0] v;
      do_reset();
      m_clear();
      n = $urandom_range(1, 15);
      press(6'(n) | (6'($urandom) & 6'h30));
      cnt = ($urandom % 4 == 0) ? $urandom_range(0, 6 * n) : 6 * n + $urandom_range(0, 2);
      for (int i = 0; i < cnt; i++) begin
        int s, r, f, d;
        f = i % 3;
        if (f == 0) begin
          v = 6'($urandom);
        end else if (f == 1) begin
          d = $urandom % 8;
          d = (d < 3) ? 0 : (d < 6) ? 1 : (d == 6) ? 2 : 3;
          v = (6'($urandom) & 6'h3c) | 6'(d);
        end else begin
          v = 6'($urandom_range(1, n));
        end
        press(v);
        if (i < 6 * n) begin
          s = i / 6 + 1;
          r = (i / 3) % 2;
          if (f == 0)      m_wr[s][r]  = v[0];
          else if (f == 1) m_dir[s][r] = int'(v[1:0]);
          else             m_nx[s][r]  = int'(v);
        end
      end
      done_press();
      start = $urandom_range(0, 63);
      press(6'(start));
      m_head = start;
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) begin
        v = 6'($urandom);
        press(v);
        m_tape[m_head] = v[0];
        m_head = (m_head + 1) % 64;
      end
      done_press();
      m_head = start;
      m_state = 1;
      chk("rand_load_head", tape_addr_out, m_head);
      chk("rand_load_state", currState, m_state);
      chk("rand_load_display", display_out, m_disp());
      rst_at = ($urandom % 5 == 0) ? $urandom_range(0, 8) : -1;
      extra = 0;
      for (int st = 0; st < 30; st++) begin
        if (st == rst_at) begin
          do_reset();
          chk("rand_reset_display", display_out, 11'd0);
          chk("rand_reset_done", Compute_done, 1'b0);
          chk("rand_reset_state", currState, 4'd0);
          break;
        end
        if ($urandom % 8 == 0) done_press();
        run_step($urandom_range(1, 3));
        if (m_done) begin
          extra++;
          if (extra > 2) break;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
